// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR): moves up to STEP bit positions per cycle, valid/ready in and out.
// Optional rotate datapath enabled by defining ITER_SHIFT_ROTATE_EN; otherwise op=10 returns 0 in one cycle.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

`ifdef ITER_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_rem;
    logic [WIDTH-1:0] r_result;

    logic [AW-1:0]    w_amt;
    logic [AW-1:0]    w_k;
    logic [WIDTH-1:0] w_step_res;
    logic             w_accept;
    logic             w_rot_off;
    logic             w_unused_b;

    assign w_amt      = b[AW-1:0];
    assign w_unused_b = ^b[WIDTH-1:AW];
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    // Without the rotate datapath, ROTR degenerates to a zero result with no shift phase.
    assign w_rot_off  = !ROT_EN && (op == OP_ROTR);
    assign result     = r_result;

    // Per-cycle shift amount: min(STEP, remaining)
    always_comb begin
        w_k = r_rem;
        if (STEP < WIDTH) begin
            if (r_rem >= AW'(STEP)) w_k = AW'(STEP);
        end
    end

`ifdef ITER_SHIFT_ROTATE_EN
    logic [AW-1:0] w_kinv;
    assign w_kinv = AW'(0) - w_k;
`endif

    always_comb begin
        w_step_res = r_result;
        case (r_op)
            OP_SLL:  w_step_res = r_result << w_k;
            OP_SRL:  w_step_res = r_result >> w_k;
            // Sign bit never changes across SRA steps, so it always equals the original a MSB.
            OP_SRA:  w_step_res = $unsigned($signed(r_result) >>> w_k);
`ifdef ITER_SHIFT_ROTATE_EN
            OP_ROTR: w_step_res = (r_result >> w_k) | (r_result << w_kinv);
`endif
            default: w_step_res = r_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = (w_rot_off || w_amt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_rem == w_k) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_SLL;
            r_rem    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_rem    <= w_rot_off ? '0 : w_amt;
            r_result <= w_rot_off ? '0 : a;
        end else if (r_state == S_SHIFT) begin
            r_rem    <= r_rem - w_k;
            r_result <= w_step_res;
        end
    end
endmodule
